adder_tree_sched: RTL and testbench
===================================

# adder_tree_sched

Issue sequencer and accumulator for the 28-input, 5-stage fixed-point adder tree. For each neuron in a layer, the block issues `CHUNKS` chunk requests, one per cycle, to the operand memories. It gates `Beta` so that beta is injected only on a neuron's first chunk. It tracks in-flight chunks through the tree with a tag pipeline and accumulates the 26-bit tree outputs into one saturated result per neuron. It sits between the layer controller and the `Adder_5Stage` datapath.

## Interface
Parameters:
- `LATENCY`, 13: cycles from an issue cycle to the cycle the corresponding `TreeResult` is valid. Includes memory read latency. Range 1 or more.
- `CHUNKS`, 28: chunks per neuron. Range 1–32.
- `NEURONS`, 10: neurons per layer. Range 1–16.

Ports:
- `clk`  in  1  clock; the block uses one clock.
- `GlobalReset`  in  1  reset; synchronous, active-high.
- `Start`  in  1  one-cycle pulse that begins a layer. Ignored unless the FSM is in IDLE.
- `Hold`  in  1  when high, no chunk issues this cycle. The tree pipeline keeps draining.
- `BetaIn`  in  26  beta for the current `IssueNeuron`, from the beta memory.
- `TreeResult`  in  26  the tree's `Result_1`.
- `IssueValid`  out  1  a chunk issues this cycle.
- `IssueChunk`  out  5  chunk index, 0..`CHUNKS`-1.
- `IssueNeuron`  out  4  neuron index, 0..`NEURONS`-1.
- `BetaOut`  out  26  `BetaIn` when `IssueValid` and `IssueChunk`==0, else 0. Combinational.
- `NeuronValid`  out  1  one-cycle pulse marking a finished neuron sum.
- `NeuronIdx`  out  4  index of the finished neuron.
- `NeuronResult`  out  26  saturated sum for that neuron.
- `Busy`  out  1  high whenever the FSM is not in IDLE.
- `Done`  out  1  one-cycle pulse when the layer completes.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE → ISSUE on `Start`. Chunk and neuron counters clear to 0.
  - ISSUE: `IssueValid` = !`Hold`.
    - On each issue the chunk counter increments.
    - When the chunk counter wraps from `CHUNKS`-1 to 0, the neuron counter increments.
    - The issue of chunk `CHUNKS`-1 of neuron `NEURONS`-1 moves the FSM to DRAIN.
  - DRAIN: no issues. When the in-flight tag pipeline is empty and no `NeuronValid` is pending, move to DONE.
  - DONE: `Done`=1 for one cycle, then the FSM returns to IDLE.
- Tag pipeline: a `LATENCY`-deep shift register of {valid, first, last, neuron[3:0]}, loaded on each issue.
  - first = (chunk==0).
  - last = (chunk==`CHUNKS`-1).
- At the tag-pipeline output, when valid is high, `TreeResult` is sampled:
  - if first: acc ← `TreeResult`.
  - otherwise: acc ← sat(acc + `TreeResult`).
  - if last: `NeuronResult` ← the new acc value, `NeuronIdx` ← the tag neuron, `NeuronValid` ← 1 on the next cycle.
- When first and last are both set (`CHUNKS`=1), `NeuronResult` = `TreeResult`.
- Arithmetic is 26-bit two's complement with a 27-bit internal sum.
  - Positive overflow clamps to 0x1FFFFFF.
  - Negative overflow clamps to 0x2000000.
- `Start` during ISSUE, DRAIN or DONE has no effect.
- `Hold` during DRAIN has no effect.

## Timing
- The first `IssueValid` occurs in the cycle after `Start`, provided `Hold`=0.
- For a chunk issued in cycle t, its `TreeResult` is consumed in cycle t+`LATENCY`.
- For a neuron whose last chunk issued at t, `NeuronValid` is high in cycle t+`LATENCY`+1.
- With `Hold`=0 throughout, a layer takes `CHUNKS`·`NEURONS` issue cycles. `Done` follows one cycle after the final `NeuronValid`.
- Registered outputs: `NeuronValid`, `NeuronIdx`, `NeuronResult`, `Done` and the FSM state.
- Combinational outputs: `IssueValid`, `IssueChunk`, `IssueNeuron`, `BetaOut` and `Busy`, decoded from the state, the counters and `Hold`.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - counters 0;
  - accumulator 0;
  - every tag valid bit 0.
- Reset mid-layer discards all in-flight tags. No `NeuronValid` or `Done` is produced for the aborted layer.

## Test plan
- Setup: `LATENCY`=3, `CHUNKS`=2, `NEURONS`=2, `TreeResult` driven as a model of the issued chunk. `Start` at cycle 0.
  - Required: issues (n0,c0),(n0,c1),(n1,c0),(n1,c1) in cycles 1–4.
  - Required: `BetaOut`=`BetaIn` in cycles 1 and 3 only.
  - Required: `NeuronValid` in cycles 6 and 8.
  - Required: `Done` in cycle 9.
- Saturation: results 0x1000000 then 0x1000000 → `NeuronResult`=0x1FFFFFF. Results 0x2000000 then 0x3FFFFFF → `NeuronResult`=0x2000000.
- `Hold` high for cycles 2–4 of a layer: issue indices resume without skipping. Each neuron sum equals the reference model value. `Done` is delayed by 3 cycles.
- `CHUNKS`=1, `TreeResult`=0x0000123 → `NeuronResult`=0x0000123 for every neuron.
- `Start` re-pulsed in ISSUE and in DRAIN → no counter change and a single `Done`.
- `GlobalReset` asserted in the cycle after the first issue:
  - outputs are 0 in the following cycle;
  - no `NeuronValid` is produced over the next 20 cycles;
  - a new `Start` then runs a clean layer.

Source files
------------

// File: rtl/adder_tree_sched.sv
// Issue sequencer and saturating accumulator for the 28-input adder tree.
// Issues one chunk per cycle per neuron, tags each chunk, and sums tree outputs per neuron.
module adder_tree_sched #(
  parameter int LATENCY = 13,
  parameter int CHUNKS  = 28,
  parameter int NEURONS = 10
) (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic        Start,
  input  logic        Hold,
  input  logic [25:0] BetaIn,
  input  logic [25:0] TreeResult,
  output logic        IssueValid,
  output logic [4:0]  IssueChunk,
  output logic [3:0]  IssueNeuron,
  output logic [25:0] BetaOut,
  output logic        NeuronValid,
  output logic [3:0]  NeuronIdx,
  output logic [25:0] NeuronResult,
  output logic        Busy,
  output logic        Done
);

  localparam logic [4:0]  LAST_CHUNK  = 5'(CHUNKS - 1);
  localparam logic [3:0]  LAST_NEURON = 4'(NEURONS - 1);
  localparam logic [25:0] SAT_POS     = 26'h1FFFFFF;
  localparam logic [25:0] SAT_NEG     = 26'h2000000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  chunk_reg;
  logic [3:0]  neuron_reg;
  logic        issue_valid;

  // Tag layout: [6] valid, [5] first chunk, [4] last chunk, [3:0] neuron
  logic [6:0]  tag_reg [LATENCY];
  logic [6:0]  tag_in;
  logic [6:0]  tag_out;
  logic        inflight;

  logic [25:0] acc_reg;
  logic [26:0] sum_ext;
  logic [25:0] sat_sum;
  logic [25:0] acc_next;
  logic        nv_reg;
  logic [3:0]  idx_reg;
  logic [25:0] res_reg;
  logic        done_reg;

  always_comb begin
    state_next  = state_reg;
    issue_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (Start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        issue_valid = !Hold;
        if (issue_valid && chunk_reg == LAST_CHUNK && neuron_reg == LAST_NEURON)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Empty pipeline means the final sum has already been registered
        if (!inflight) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_reg  <= S_IDLE;
      chunk_reg  <= '0;
      neuron_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && Start) begin
        chunk_reg  <= '0;
        neuron_reg <= '0;
      end else if (issue_valid) begin
        if (chunk_reg == LAST_CHUNK) begin
          chunk_reg  <= '0;
          neuron_reg <= (neuron_reg == LAST_NEURON) ? 4'd0 : neuron_reg + 4'd1;
        end else begin
          chunk_reg <= chunk_reg + 5'd1;
        end
      end
    end
  end

  assign tag_in = {issue_valid, chunk_reg == 5'd0, chunk_reg == LAST_CHUNK, neuron_reg};

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (GlobalReset) tag_reg[gi] <= '0;
          else             tag_reg[gi] <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (GlobalReset) tag_reg[gi] <= '0;
          else             tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_out = tag_reg[LATENCY-1];

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight | tag_reg[i][6];
  end

  // 27-bit sum: the top two bits disagree exactly when the 26-bit result overflowed
  assign sum_ext  = {acc_reg[25], acc_reg} + {TreeResult[25], TreeResult};
  assign sat_sum  = (sum_ext[26] != sum_ext[25]) ? (sum_ext[26] ? SAT_NEG : SAT_POS)
                                                 : sum_ext[25:0];
  assign acc_next = tag_out[5] ? TreeResult : sat_sum;

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      acc_reg  <= '0;
      nv_reg   <= 1'b0;
      idx_reg  <= '0;
      res_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      nv_reg   <= 1'b0;
      done_reg <= (state_next == S_DONE);
      if (tag_out[6]) begin
        acc_reg <= acc_next;
        if (tag_out[4]) begin
          nv_reg  <= 1'b1;
          idx_reg <= tag_out[3:0];
          res_reg <= acc_next;
        end
      end
    end
  end

  assign IssueValid   = issue_valid;
  assign IssueChunk   = chunk_reg;
  assign IssueNeuron  = neuron_reg;
  assign BetaOut      = (issue_valid && chunk_reg == 5'd0) ? BetaIn : 26'd0;
  assign Busy         = (state_reg != S_IDLE);
  assign NeuronValid  = nv_reg;
  assign NeuronIdx    = idx_reg;
  assign NeuronResult = res_reg;
  assign Done         = done_reg;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: a small layer (L=3, C=2, N=2) driven by a tree model,
// plus a single-chunk instance (L=3, C=1, N=3) fed a constant tree result.
module tb_adder_tree_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, hold_a;
  logic [25:0] beta_a, tree_a;
  logic        iss_valid_a, nv_a, busy_a, done_a;
  logic [4:0]  iss_chunk_a;
  logic [3:0]  iss_neuron_a, nv_idx_a;
  logic [25:0] beta_out_a, nv_res_a;

  logic        start_b;
  logic        hold_b;
  logic [25:0] beta_b, tree_b;
  logic        iss_valid_b, nv_b, busy_b, done_b;
  logic [4:0]  iss_chunk_b;
  logic [3:0]  iss_neuron_b, nv_idx_b;
  logic [25:0] beta_out_b, nv_res_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_tree_sched #(.LATENCY(3), .CHUNKS(2), .NEURONS(2)) dut_a (
    .clk(clk), .GlobalReset(rst), .Start(start_a), .Hold(hold_a),
    .BetaIn(beta_a), .TreeResult(tree_a),
    .IssueValid(iss_valid_a), .IssueChunk(iss_chunk_a), .IssueNeuron(iss_neuron_a),
    .BetaOut(beta_out_a), .NeuronValid(nv_a), .NeuronIdx(nv_idx_a),
    .NeuronResult(nv_res_a), .Busy(busy_a), .Done(done_a)
  );

  adder_tree_sched #(.LATENCY(3), .CHUNKS(1), .NEURONS(3)) dut_b (
    .clk(clk), .GlobalReset(rst), .Start(start_b), .Hold(hold_b),
    .BetaIn(beta_b), .TreeResult(tree_b),
    .IssueValid(iss_valid_b), .IssueChunk(iss_chunk_b), .IssueNeuron(iss_neuron_b),
    .BetaOut(beta_out_b), .NeuronValid(nv_b), .NeuronIdx(nv_idx_b),
    .NeuronResult(nv_res_b), .Busy(busy_b), .Done(done_b)
  );

  // Beta memory: neuron n holds 0x100*(n+1)
  assign beta_a = {14'd0, iss_neuron_a + 4'd1, 8'd0};
  assign beta_b = 26'h55;
  assign tree_b = 26'h123;

  // Tree model: the value issued in cycle k reappears on tree_a in cycle k+3
  int          tree_mode = 0;
  int          cyc = 0;
  logic [25:0] hist [64];

  initial begin
    for (int i = 0; i < 64; i++) hist[i] = '0;
    tree_a = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tree_a = (cyc >= 3) ? hist[(cyc - 3) % 64] : 26'd0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!iss_valid_a)       hist[cyc % 64] = 26'd0;
      else if (tree_mode == 1) hist[cyc % 64] = 26'h1000000;
      else if (tree_mode == 2) hist[cyc % 64] = (iss_chunk_a == 5'd0) ? 26'h2000000 : 26'h3FFFFFF;
      else hist[cyc % 64] = beta_out_a + {18'd0, iss_neuron_a + 4'd1, 4'd0}
                            + {21'd0, iss_chunk_a} + 26'd1;
    end
  end

  // Per-layer observation record, filled by run_layer
  int          iss_cnt, nv_cnt, done_cnt, done_cyc, busy_cnt;
  int          iss_cyc [16];
  logic [4:0]  iss_c [16];
  logic [3:0]  iss_n [16];
  logic [25:0] iss_beta [16];
  int          nv_cyc [8];
  logic [3:0]  nv_idx [8];
  logic [25:0] nv_res [8];

  task automatic run_layer(input int hs, input int he, input int s1, input int s2, input int ncyc);
    iss_cnt = 0; nv_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    for (int k = 0; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start_a = (k == 0) || (k == s1) || (k == s2);
      hold_a  = (k >= hs) && (k <= he);
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (iss_valid_a && iss_cnt < 16) begin
        iss_cyc[iss_cnt] = k; iss_c[iss_cnt] = iss_chunk_a;
        iss_n[iss_cnt] = iss_neuron_a; iss_beta[iss_cnt] = beta_out_a;
        iss_cnt++;
      end
      if (nv_a && nv_cnt < 8) begin
        nv_cyc[nv_cnt] = k; nv_idx[nv_cnt] = nv_idx_a; nv_res[nv_cnt] = nv_res_a;
        $display("cycle %0d: neuron %0d sum %h", k, nv_idx_a, nv_res_a);
        nv_cnt++;
      end
      if (done_a) begin
        done_cnt++; done_cyc = k;
        $display("cycle %0d: layer done", k);
      end
    end
    @(posedge clk); #1;
    start_a = 1'b0; hold_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({iss_valid_a, busy_a, nv_a, done_a} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got %b want 0000", {iss_valid_a, busy_a, nv_a, done_a}); end
    checks++; if ({iss_chunk_a, iss_neuron_a, nv_idx_a} !== 13'd0) begin
      failures++; $display("FAIL reset_indices got %h want 0", {iss_chunk_a, iss_neuron_a, nv_idx_a}); end
    checks++; if (nv_res_a !== 26'd0) begin
      failures++; $display("FAIL reset_result got %h want 0", nv_res_a); end
    checks++; if (beta_out_a !== 26'd0) begin
      failures++; $display("FAIL reset_beta got %h want 0", beta_out_a); end
    checks++; if ({iss_valid_b, busy_b, nv_b, done_b} !== 4'b0) begin
      failures++; $display("FAIL reset_flags_b got %b want 0000", {iss_valid_b, busy_b, nv_b, done_b}); end
  endtask

  task automatic test_basic();
    tree_mode = 0;
    run_layer(-1, -1, -1, -1, 12);
    checks++; if (iss_cnt !== 4) begin
      failures++; $display("FAIL basic_issue_count got %0d want 4", iss_cnt); end
    for (int i = 0; i < 4 && i < iss_cnt; i++) begin
      checks++;
      if (iss_cyc[i] !== i + 1 || iss_n[i] !== 4'(i / 2) || iss_c[i] !== 5'(i % 2)) begin
        failures++;
        $display("FAIL basic_issue%0d got cyc %0d n%0d c%0d want cyc %0d n%0d c%0d",
                 i, iss_cyc[i], iss_n[i], iss_c[i], i + 1, i / 2, i % 2);
      end
      checks++;
      if (iss_beta[i] !== ((i % 2 == 0) ? 26'h100 * 26'(i / 2 + 1) : 26'd0)) begin
        failures++; $display("FAIL basic_beta%0d got %h", i, iss_beta[i]);
      end
    end
    checks++; if (nv_cnt !== 2) begin
      failures++; $display("FAIL basic_nv_count got %0d want 2", nv_cnt); end
    checks++; if (nv_cyc[0] !== 6 || nv_idx[0] !== 4'd0 || nv_res[0] !== 26'h123) begin
      failures++; $display("FAIL basic_nv0 got cyc %0d idx %0d res %h want 6 0 123", nv_cyc[0], nv_idx[0], nv_res[0]); end
    checks++; if (nv_cyc[1] !== 8 || nv_idx[1] !== 4'd1 || nv_res[1] !== 26'h243) begin
      failures++; $display("FAIL basic_nv1 got cyc %0d idx %0d res %h want 8 1 243", nv_cyc[1], nv_idx[1], nv_res[1]); end
    checks++; if (done_cnt !== 1 || done_cyc !== 9) begin
      failures++; $display("FAIL basic_done got count %0d cyc %0d want 1 9", done_cnt, done_cyc); end
    checks++; if (busy_cnt !== 9) begin
      failures++; $display("FAIL basic_busy got %0d cycles want 9", busy_cnt); end
  endtask

  task automatic test_saturation();
    tree_mode = 1;
    run_layer(-1, -1, -1, -1, 12);
    checks++; if (nv_cnt !== 2 || nv_res[0] !== 26'h1FFFFFF || nv_res[1] !== 26'h1FFFFFF) begin
      failures++; $display("FAIL sat_pos got cnt %0d %h %h want 1ffffff", nv_cnt, nv_res[0], nv_res[1]); end
    tree_mode = 2;
    run_layer(-1, -1, -1, -1, 12);
    checks++; if (nv_cnt !== 2 || nv_res[0] !== 26'h2000000 || nv_res[1] !== 26'h2000000) begin
      failures++; $display("FAIL sat_neg got cnt %0d %h %h want 2000000", nv_cnt, nv_res[0], nv_res[1]); end
    tree_mode = 0;
  endtask

  task automatic test_hold();
    run_layer(2, 4, -1, -1, 15);
    checks++; if (iss_cnt !== 4) begin
      failures++; $display("FAIL hold_issue_count got %0d want 4", iss_cnt); end
    for (int i = 0; i < 4 && i < iss_cnt; i++) begin
      checks++;
      if (iss_cyc[i] !== ((i == 0) ? 1 : i + 4) || iss_n[i] !== 4'(i / 2) || iss_c[i] !== 5'(i % 2)) begin
        failures++;
        $display("FAIL hold_issue%0d got cyc %0d n%0d c%0d", i, iss_cyc[i], iss_n[i], iss_c[i]);
      end
    end
    checks++; if (nv_res[0] !== 26'h123 || nv_res[1] !== 26'h243 || nv_cyc[0] !== 9 || nv_cyc[1] !== 11) begin
      failures++; $display("FAIL hold_sums got %h@%0d %h@%0d want 123@9 243@11", nv_res[0], nv_cyc[0], nv_res[1], nv_cyc[1]); end
    checks++; if (done_cnt !== 1 || done_cyc !== 12) begin
      failures++; $display("FAIL hold_done got count %0d cyc %0d want 1 12", done_cnt, done_cyc); end
  endtask

  task automatic test_restart();
    run_layer(-1, -1, 2, 6, 14);
    checks++; if (iss_cnt !== 4 || iss_n[1] !== 4'd0 || iss_c[1] !== 5'd1) begin
      failures++; $display("FAIL restart_issues got %0d issues, second n%0d c%0d", iss_cnt, iss_n[1], iss_c[1]); end
    checks++; if (done_cnt !== 1 || done_cyc !== 9) begin
      failures++; $display("FAIL restart_done got count %0d cyc %0d want 1 9", done_cnt, done_cyc); end
  endtask

  task automatic test_abort_reset();
    int nv_seen = 0;
    int done_seen = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    checks++; if (iss_valid_a !== 1'b1) begin
      failures++; $display("FAIL abort_first_issue got %b want 1", iss_valid_a); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({iss_valid_a, busy_a, nv_a, done_a, iss_chunk_a, iss_neuron_a} !== 13'd0 || nv_res_a !== 26'd0) begin
      failures++; $display("FAIL abort_outputs got %b res %h want 0",
                           {iss_valid_a, busy_a, nv_a, done_a, iss_chunk_a, iss_neuron_a}, nv_res_a); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (nv_a) nv_seen++;
      if (done_a) done_seen++;
    end
    checks++; if (nv_seen !== 0 || done_seen !== 0) begin
      failures++; $display("FAIL abort_quiet got nv %0d done %0d want 0 0", nv_seen, done_seen); end
    run_layer(-1, -1, -1, -1, 12);
    checks++; if (nv_cnt !== 2 || nv_res[0] !== 26'h123 || nv_res[1] !== 26'h243 || done_cnt !== 1) begin
      failures++; $display("FAIL abort_rerun got cnt %0d %h %h done %0d", nv_cnt, nv_res[0], nv_res[1], done_cnt); end
  endtask

  task automatic test_single_chunk();
    int nb = 0;
    int ib = 0;
    int db = -1;
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk); #1 start_b = (k == 0);
      @(negedge clk);
      if (iss_valid_b) begin
        checks++;
        if (beta_out_b !== 26'h55 || iss_chunk_b !== 5'd0 || iss_neuron_b !== 4'(ib)) begin
          failures++; $display("FAIL single_issue%0d got beta %h c%0d n%0d", ib, beta_out_b, iss_chunk_b, iss_neuron_b);
        end
        ib++;
      end
      if (nv_b) begin
        $display("cycle %0d: single-chunk neuron %0d sum %h", k, nv_idx_b, nv_res_b);
        checks++;
        if (nv_res_b !== 26'h123 || nv_idx_b !== 4'(nb) || k !== nb + 5) begin
          failures++; $display("FAIL single_nv%0d got res %h idx %0d cyc %0d want 123 %0d %0d",
                               nb, nv_res_b, nv_idx_b, k, nb, nb + 5);
        end
        nb++;
      end
      if (done_b) db = k;
    end
    checks++; if (ib !== 3 || nb !== 3 || db !== 8) begin
      failures++; $display("FAIL single_counts got issues %0d nv %0d done %0d want 3 3 8", ib, nb, db); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_restart();
    test_abort_reset();
    test_single_chunk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
